// File: rtl/apb_request_arbiter.sv
// Round-robin front end sharing one APB_Master between NO_REQ requesters.
// One transfer in flight; completion returns a one-cycle response pulse to its owner.
module apb_request_arbiter #(
    parameter int NO_REQ         = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int NO_SLAVES      = 2,
    parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic [NO_REQ-1:0]                req_valid,
    output logic [NO_REQ-1:0]                req_ready,
    input  logic [NO_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NO_REQ*3-1:0]              req_prot,
    input  logic [NO_REQ*NO_SLAVES-1:0]      req_sel,
    input  logic [NO_REQ-1:0]                req_write,
    input  logic [NO_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NO_REQ*BYTES_PER_WORD-1:0] req_strb,
    output logic [NO_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             master_transfer,
    output logic [ADDR_WIDTH-1:0]            master_address,
    output logic [2:0]                       master_protection,
    output logic [NO_SLAVES-1:0]             master_select,
    output logic                             master_read_write,
    output logic [DATA_WIDTH-1:0]            master_write_data,
    output logic [BYTES_PER_WORD-1:0]        master_strobe,
    input  logic                             slave_data_ready,
    input  logic [DATA_WIDTH-1:0]            slave_read_data,
    input  logic                             slave_error
);

    localparam int PTR_W = (NO_REQ > 1) ? $clog2(NO_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETUP,
        ST_ACCESS
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [2:0]                prot;
        logic [NO_SLAVES-1:0]      sel;
        logic                      write;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [BYTES_PER_WORD-1:0] strb;
    } cmd_t;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    cmd_t                  cmd_q, cmd_d;
    logic [NO_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  grant_found;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      scan_idx;
    cmd_t                  grant_cmd;

    // Scan ptr+1, ptr+2, ... (mod NO_REQ); the last owner has lowest priority.
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 1; k <= NO_REQ; k++) begin
            scan_idx = PTR_W'((int'(ptr_q) + k) % NO_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        grant_cmd = '0;
        for (int i = 0; i < NO_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                grant_cmd.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                grant_cmd.prot  = req_prot[i*3 +: 3];
                grant_cmd.sel   = req_sel[i*NO_SLAVES +: NO_SLAVES];
                grant_cmd.write = req_write[i];
                grant_cmd.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                grant_cmd.strb  = req_strb[i*BYTES_PER_WORD +: BYTES_PER_WORD];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cmd_d       = cmd_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    // Accept pulse is masked while reset is held so outputs read 0 immediately.
                    req_ready[grant_idx] = ~preset;
                    cmd_d                = grant_cmd;
                    ptr_d                = grant_idx;
                    state_d              = ST_ISSUE;
                end
            end
            ST_ISSUE:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (slave_data_ready) begin
                    rsp_valid_d[ptr_q] = 1'b1;
                    rsp_rdata_d        = slave_read_data;
                    rsp_err_d          = slave_error;
                    state_d            = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PTR_W'(NO_REQ - 1);
            cmd_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign master_transfer   = (state_q == ST_ISSUE);
    assign master_address    = cmd_q.addr;
    assign master_protection = cmd_q.prot;
    assign master_select     = cmd_q.sel;
    assign master_read_write = cmd_q.write;
    assign master_write_data = cmd_q.wdata;
    assign master_strobe     = cmd_q.strb;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
